// File: rtl/iob_ssd_arbiter.sv
// Round-robin arbiter sharing one seven-segment display core between N_REQ requesters,
// with a programmable minimum dwell time per grant.
module iob_ssd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int DWELL_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data,
  output logic [N_REQ-1:0]          grant,
  output logic [$clog2(N_REQ)-1:0]  owner_id,
  output logic                      busy,
  output logic [DATA_W-1:0]         ssd_data
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state, state_n;
  logic [IDW-1:0]      last, last_n, owner_n;
  logic [N_REQ-1:0]    grant_n;
  logic                busy_n;
  logic [DATA_W-1:0]   ssd_data_n;
  logic [DWELL_W-1:0]  cnt, cnt_n, dwell_m1;
  logic                expired;
  logic [IDW:0]        pick_idle, pick_hand;

  // Returns {found, index}: first set bit scanning base+1, base+2, ... with wrap.
  function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IDW-1:0] base);
    logic [IDW:0]   res;
    logic [IDW-1:0] p;
    res = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      p = IDW'((32'(base) + k) % N_REQ);
      if (!res[IDW] && r[p]) res = {1'b1, p};
    end
    return res;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    logic [N_REQ-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] word(input logic [N_REQ*DATA_W-1:0] d, input logic [IDW-1:0] idx);
    return d[32'(idx)*DATA_W +: DATA_W];
  endfunction

  assign dwell_m1  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign expired   = (cnt >= dwell_m1);
  assign pick_idle = rr_pick(req, last);
  // Masking the owner out means a hit here is always a different requester.
  assign pick_hand = rr_pick(req & ~onehot(owner_id), owner_id);

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    owner_n    = owner_id;
    last_n     = last;
    busy_n     = busy;
    cnt_n      = cnt;
    ssd_data_n = ssd_data;
    case (state)
      IDLE: begin
        if (pick_idle[IDW]) begin
          state_n    = HOLD;
          grant_n    = onehot(pick_idle[IDW-1:0]);
          owner_n    = pick_idle[IDW-1:0];
          last_n     = pick_idle[IDW-1:0];
          busy_n     = 1'b1;
          cnt_n      = '0;
          ssd_data_n = word(data, pick_idle[IDW-1:0]);
        end
      end
      HOLD: begin
        ssd_data_n = word(data, owner_id);
        cnt_n      = (cnt == '1) ? cnt : cnt + DWELL_W'(1);
        if (!req[owner_id]) begin
          // Release freezes the display word rather than taking one more live sample.
          state_n    = IDLE;
          grant_n    = '0;
          busy_n     = 1'b0;
          ssd_data_n = ssd_data;
        end else if (expired && pick_hand[IDW]) begin
          grant_n    = onehot(pick_hand[IDW-1:0]);
          owner_n    = pick_hand[IDW-1:0];
          last_n     = pick_hand[IDW-1:0];
          cnt_n      = '0;
          ssd_data_n = word(data, pick_hand[IDW-1:0]);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      owner_id <= '0;
      last     <= IDW'(N_REQ - 1);
      busy     <= 1'b0;
      cnt      <= '0;
      ssd_data <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      owner_id <= owner_n;
      last     <= last_n;
      busy     <= busy_n;
      cnt      <= cnt_n;
      ssd_data <= ssd_data_n;
    end
  end

endmodule
